// File: rtl/systolic_ctrl_pkg.sv
// Shared constants and FSM encodings for the systolic array sequencer.
package systolic_ctrl_pkg;

  localparam int ARRAY_N        = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_K_WIDTH    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Drain counter must hold 0..2N.
  function automatic int drain_cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// DEPTH-stage register chain carrying data plus its valid; DEPTH 0 is a wire.
module skew_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
  end else begin : g_chain
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    // Unqualified inputs load 0 so the chain carries 0 outside valid windows.
    always_comb begin
      data_d[0]  = valid_i ? data_i : '0;
      valid_d    = '0;
      valid_d[0] = valid_i;
      for (int s = 1; s < DEPTH; s++) begin
        data_d[s]  = data_q[s-1];
        valid_d[s] = valid_q[s-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
      end else begin
        valid_q <= valid_d;
        for (int s = 0; s < DEPTH; s++) data_q[s] <= data_d[s];
      end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: issues operand
// reads, skews them onto the array edges and flags when all psums are final.
//
//   state | meaning
//   IDLE  | waiting for start with nonzero K
//   FEED  | K cycles of operand reads, rd_addr = k
//   DRAIN | 2N cycles for the wavefront to reach PE(N-1,N-1)
//   DONE  | one cycle, all psums final; may restart back-to-back
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int N          = ARRAY_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K_WIDTH    = DEF_K_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [K_WIDTH-1:0]      k_len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    rd_en_o,
  output logic [K_WIDTH-1:0]      rd_addr_o,
  input  logic [N*DATA_WIDTH-1:0] buf_a_i,
  input  logic [N*DATA_WIDTH-1:0] buf_b_i,
  output logic [N*DATA_WIDTH-1:0] array_a_o,
  output logic [N*DATA_WIDTH-1:0] array_b_o,
  output logic [N-1:0]            array_clear_o
);

  localparam int DCW = drain_cnt_width(N);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 1);

  logic [1:0]         state_q, state_d;
  logic [K_WIDTH-1:0] k_cnt_q, k_cnt_d;
  logic [K_WIDTH-1:0] k_len_q, k_len_d;
  logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
  logic               rd_valid_q, rd_valid_d;
  logic               clr_src_q, clr_src_d;
  logic               accept;

  assign accept = start_i && (k_len_i != '0);

  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    k_len_d     = k_len_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_FEED;
          k_len_d = k_len_i;
        end
      end
      ST_FEED: begin
        // Compare against K-1 so K = 2^K_WIDTH-1 never wraps the counter.
        if (k_cnt_q == k_len_q - K_WIDTH'(1)) begin
          state_d = ST_DRAIN;
          k_cnt_d = '0;
        end else begin
          k_cnt_d = k_cnt_q + K_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = ST_DONE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_d = ST_FEED;
          k_len_d = k_len_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer data lags the read by one cycle; qualify it and the k = 0 clear.
  assign rd_valid_d = (state_q == ST_FEED);
  assign clr_src_d  = (state_q == ST_FEED) && (k_cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      k_cnt_q     <= '0;
      k_len_q     <= '0;
      drain_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      clr_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      k_len_q     <= k_len_d;
      drain_cnt_q <= drain_cnt_d;
      rd_valid_q  <= rd_valid_d;
      clr_src_q   <= clr_src_d;
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign rd_en_o   = (state_q == ST_FEED);
  assign rd_addr_o = k_cnt_q;

  for (genvar i = 0; i < N; i++) begin : g_edge
    logic                  a_vld, b_vld, c_vld;
    logic [DATA_WIDTH-1:0] a_dat, b_dat;
    logic [0:0]            c_dat;

    skew_line #(.WIDTH(DATA_WIDTH), .DEPTH(i)) u_skew_a (
      .clk_i, .rst_ni,
      .valid_i (rd_valid_q),
      .data_i  (buf_a_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o (a_vld),
      .data_o  (a_dat)
    );

    skew_line #(.WIDTH(DATA_WIDTH), .DEPTH(i)) u_skew_b (
      .clk_i, .rst_ni,
      .valid_i (rd_valid_q),
      .data_i  (buf_b_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o (b_vld),
      .data_o  (b_dat)
    );

    skew_line #(.WIDTH(1), .DEPTH(i)) u_skew_clr (
      .clk_i, .rst_ni,
      .valid_i (rd_valid_q),
      .data_i  (clr_src_q),
      .valid_o (c_vld),
      .data_o  (c_dat)
    );

    assign array_a_o[i*DATA_WIDTH +: DATA_WIDTH] = a_vld ? a_dat : '0;
    assign array_b_o[i*DATA_WIDTH +: DATA_WIDTH] = b_vld ? b_dat : '0;
    assign array_clear_o[i]                      = c_vld & c_dat[0];
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl: per-cycle edge timing from job-relative
// formulas, plus a behavioural PE array whose results are checked at done.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int KW = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [KW-1:0]   k_len_i = '0;
  logic            busy_o, done_o, rd_en_o;
  logic [KW-1:0]   rd_addr_o;
  logic [N*DW-1:0] buf_a_i = '0;
  logic [N*DW-1:0] buf_b_i = '0;
  logic [N*DW-1:0] array_a_o, array_b_o;
  logic [N-1:0]    array_clear_o;

  systolic_ctrl #(.N(N), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .k_len_i       (k_len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .rd_en_o       (rd_en_o),
    .rd_addr_o     (rd_addr_o),
    .buf_a_i       (buf_a_i),
    .buf_b_i       (buf_b_i),
    .array_a_o     (array_a_o),
    .array_b_o     (array_b_o),
    .array_clear_o (array_clear_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // mem_x[k][i]: A[i][k] / B[k][i] of the running job; nxt_x staged for the next.
  logic [DW-1:0] mem_a [256][N];
  logic [DW-1:0] mem_b [256][N];
  logic [DW-1:0] nxt_a [256][N];
  logic [DW-1:0] nxt_b [256][N];
  int            refc  [N][N];
  bit            cur_valid = 1'b0;
  int            cur_s = 0;
  int            cur_k = 0;

  // Behavioural PE array: a flows east with clear, b flows south.
  int            psum  [N][N];
  logic [DW-1:0] pe_a  [N][N];
  logic [DW-1:0] pe_b  [N][N];
  logic          pe_c  [N][N];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
  endtask

  function automatic int qmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return (sa * sb) >>> 8;
  endfunction

  task automatic pe_step(input logic [N*DW-1:0] ea, input logic [N*DW-1:0] eb, input logic [N-1:0] ec);
    int            ns [N][N];
    logic [DW-1:0] na [N][N];
    logic [DW-1:0] nb [N][N];
    logic          nc [N][N];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        na[i][j] = (j == 0) ? ea[i*DW +: DW] : pe_a[i][j-1];
        nc[i][j] = (j == 0) ? ec[i]          : pe_c[i][j-1];
        nb[i][j] = (i == 0) ? eb[j*DW +: DW] : pe_b[i-1][j];
        ns[i][j] = nc[i][j] ? qmul(na[i][j], nb[i][j]) : psum[i][j] + qmul(na[i][j], nb[i][j]);
      end
    psum = ns;
    pe_a = na;
    pe_b = nb;
    pe_c = nc;
  endtask

  task automatic tick();
    logic [N*DW-1:0] ea, eb;
    logic [N-1:0]    ec;
    bit              act, feed;
    int              rel, c;
    logic            rd_s;
    logic [KW-1:0]   addr_s;
    @(negedge clk_i);
    rel  = cyc - cur_s;
    act  = cur_valid && rel >= 0 && rel <= cur_k + 2*N;
    feed = cur_valid && rel >= 0 && rel < cur_k;
    ea = '0; eb = '0; ec = '0;
    for (int i = 0; i < N; i++) begin
      c = rel - 1 - i;
      if (cur_valid && c >= 0 && c < cur_k) begin
        ea[i*DW +: DW] = mem_a[c][i];
        eb[i*DW +: DW] = mem_b[c][i];
      end
      if (cur_valid && rel == 1 + i) ec[i] = 1'b1;
    end
    check_val("busy", 64'(busy_o), 64'(act));
    check_val("done", 64'(done_o), 64'(act && rel == cur_k + 2*N));
    check_val("rd_en", 64'(rd_en_o), 64'(feed));
    if (feed) check_val("rd_addr", 64'(rd_addr_o), 64'(rel));
    check_val("array_a", 64'(array_a_o), 64'(ea));
    check_val("array_b", 64'(array_b_o), 64'(eb));
    check_val("clear", 64'(array_clear_o), 64'(ec));
    if (act && rel == cur_k + 2*N)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          check_val($sformatf("c_%0d_%0d", i, j), 64'(psum[i][j]), 64'(refc[i][j]));
    pe_step(array_a_o, array_b_o, array_clear_o);
    if (rst_ni && start_i && k_len_i != '0 && !(act && rel < cur_k + 2*N)) begin
      cur_valid = 1'b1;
      cur_s     = cyc + 1;
      cur_k     = int'(k_len_i);
      mem_a     = nxt_a;
      mem_b     = nxt_b;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          refc[i][j] = 0;
          for (int k = 0; k < cur_k; k++) refc[i][j] += qmul(mem_a[k][i], mem_b[k][j]);
        end
    end
    rd_s   = rd_en_o;
    addr_s = rd_addr_o;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++) begin
      buf_a_i[i*DW +: DW] = rd_s ? mem_a[addr_s][i] : DW'($urandom);
      buf_b_i[i*DW +: DW] = rd_s ? mem_b[addr_s][i] : DW'($urandom);
    end
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  task automatic drive(input logic st, input int kl);
    start_i = st;
    k_len_i = KW'(kl);
  endtask

  task automatic mats_rand(input int kmax);
    for (int k = 0; k < kmax; k++)
      for (int i = 0; i < N; i++) begin
        nxt_a[k][i] = DW'($urandom_range(0, 16'h03ff));
        nxt_b[k][i] = DW'($urandom_range(0, 16'h03ff));
      end
  endtask

  task automatic run_job(input int k);
    drive(1'b1, k);
    tick();
    drive(1'b0, 0);
    ticks(k + 2*N + 2);
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        psum[i][j] = 0; pe_a[i][j] = '0; pe_b[i][j] = '0; pe_c[i][j] = 1'b0;
        refc[i][j] = 0;
      end
    for (int k = 0; k < 256; k++)
      for (int i = 0; i < N; i++) begin
        nxt_a[k][i] = '0; nxt_b[k][i] = '0; mem_a[k][i] = '0; mem_b[k][i] = '0;
      end

    // Reset state, then release away from the edge.
    ticks(3);
    rst_ni = 1'b1;
    ticks(2);

    // Identity operands, K=3.
    for (int k = 0; k < 256; k++)
      for (int i = 0; i < N; i++) begin
        nxt_a[k][i] = (k == i) ? 16'h0100 : 16'h0000;
        nxt_b[k][i] = (k == i) ? 16'h0100 : 16'h0000;
      end
    run_job(3);

    // A[i][k] = i+1, B[k][j] = j+1, K=4.
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) begin
        nxt_a[k][i] = DW'((i + 1) << 8);
        nxt_b[k][i] = DW'((i + 1) << 8);
      end
    run_job(4);

    // K=0 start is ignored.
    drive(1'b1, 0);
    ticks(3);
    drive(1'b0, 0);
    ticks(1);

    // Back-to-back: K=2, then K=5 accepted during DONE.
    mats_rand(2);
    drive(1'b1, 2);
    tick();
    drive(1'b0, 0);
    mats_rand(5);
    while (cyc < cur_s + cur_k + 2*N - 2) tick();
    drive(1'b1, 5);
    ticks(3);
    drive(1'b0, 0);
    ticks(5 + 2*N + 2);

    // Starts mid-FEED and mid-DRAIN are ignored.
    mats_rand(6);
    drive(1'b1, 6);
    tick();
    drive(1'b0, 0);
    ticks(2);
    drive(1'b1, 3);
    tick();
    drive(1'b0, 0);
    ticks(5);
    drive(1'b1, 7);
    tick();
    drive(1'b0, 0);
    ticks(6 + 2*N);

    // Asynchronous reset in DRAIN aborts the job.
    mats_rand(3);
    drive(1'b1, 3);
    tick();
    drive(1'b0, 0);
    ticks(5);
    #1 rst_ni = 1'b0;
    #1;
    check_val("rst_busy", 64'(busy_o), 64'(0));
    check_val("rst_rd_en", 64'(rd_en_o), 64'(0));
    check_val("rst_addr", 64'(rd_addr_o), 64'(0));
    check_val("rst_array_a", 64'(array_a_o), 64'(0));
    check_val("rst_array_b", 64'(array_b_o), 64'(0));
    check_val("rst_clear", 64'(array_clear_o), 64'(0));
    cur_valid = 1'b0;
    ticks(12);
    rst_ni = 1'b1;
    mats_rand(3);
    run_job(3);

    // Longest legal K.
    mats_rand(255);
    run_job(255);

    // Random start traffic, including K=0 and ignored requests.
    for (int t = 0; t < 300; t++) begin
      mats_rand(12);
      drive(($urandom_range(0, 5) == 0), $urandom_range(0, 12));
      tick();
    end
    drive(1'b0, 0);
    ticks(12 + 2*N + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
